// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Serialised single-word read/write controller in front of
//               main_memory; optional alignment fault with MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] c_cnt_load = 2'(RD_LATENCY - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        w_misaligned;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = |req_addr[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= 32'd0;
            r_mem_address <= 32'd0;
            r_mem_data_in <= 32'd0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            // Strobes and the response pulse are single-cycle unless re-armed below.
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_mem_address <= req_addr;
                        r_mem_data_in <= req_wdata;
                        r_req_ready   <= 1'b0;
                        if (w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (req_we) begin
                            r_state  <= S_WRITE;
                            r_mem_wr <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                    r_cnt   <= c_cnt_load;
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_resp_rdata <= mem_data_out;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed bench for mem_access_ctrl (latency 1 and 3 instances)
//               with a small main_memory model; honours MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;

    logic        req3, req_we3;
    logic [31:0] req_addr3, req_wdata3;
    logic        req_ready3, resp_valid3, resp_err3, mem_rd3, mem_wr3;
    logic [31:0] resp_rdata3, mem_address3, mem_data_in3, mem_data_out3;

    logic        mem_load;
    logic [31:0] mem [0:1023];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out)
    );

    mem_access_ctrl #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_we(req_we3), .req_addr(req_addr3),
        .req_wdata(req_wdata3), .req_ready(req_ready3), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .mem_address(mem_address3),
        .mem_data_in(mem_data_in3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
        .mem_data_out(mem_data_out3)
    );

    // Memory model: registered read, data valid N edges after rd is sampled;
    // outside that window the read port shows a poison value.
    always @(posedge clk) begin
        if (mem_load) begin
            mem[512] <= 32'hc2002844;
            mem[513] <= 32'h82804002;
            mem[529] <= 32'h00000001;
        end else if (mem_wr) begin
            mem[mem_address[11:2]] <= mem_data_in;
        end
        pipe1    <= mem_rd  ? mem[mem_address[11:2]]  : 32'hDEADBEEF;
        pipe3[0] <= mem_rd3 ? mem[mem_address3[11:2]] : 32'hDEADBEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_data_out  = pipe1;
    assign mem_data_out3 = pipe3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge in an IDLE cycle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic hold, input logic [31:0] next_addr);
        int n;
        chk("idle_ready", 32'(req_ready), 32'd1);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = exp_err ? 1 : (we ? 2 : 3);
        if (!we && !exp_err) model_rdata = exp_rdata;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) req_addr = next_addr;
                else      req = 1'b0;
            end
            chk("ready_busy",  32'(req_ready),  32'd0);
            chk("mem_rd",      32'(mem_rd),     32'(!exp_err && !we && k == 1));
            chk("mem_wr",      32'(mem_wr),     32'(!exp_err &&  we && k == 1));
            chk("resp_valid",  32'(resp_valid), 32'(k == n));
            chk("mem_address", mem_address, addr);
            chk("mem_data_in", mem_data_in, wdata);
            if (k == n) begin
                chk("resp_rdata", resp_rdata, model_rdata);
                chk("resp_err",   32'(resp_err), 32'(exp_err));
            end
        end
        @(negedge clk);
        chk("ready_back",    32'(req_ready),  32'd1);
        chk("idle_valid",    32'(resp_valid), 32'd0);
        chk("idle_strobes",  32'({mem_rd, mem_wr}), 32'd0);
        chk("idle_addr_hold", mem_address, addr);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        hold;
        logic [31:0] next_addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
`ifdef MEM_ALIGN_CHECK_EN
        vecs[5] = '{1'b0, 32'd2090, 32'h0BAD0BAD, 32'h0,       1'b1, 1'b0, 32'd0};
`else
        vecs[5] = '{1'b0, 32'd2090, 32'h0BAD0BAD, 32'h12345678, 1'b0, 1'b0, 32'd0};
`endif
        vecs[0] = '{1'b0, 32'd2116, 32'hAAAA5555, 32'h00000001, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 32'd2088, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 32'd2088, 32'h55AA55AA, 32'h12345678, 1'b0, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 32'd2048, 32'h00000000, 32'hc2002844, 1'b0, 1'b1, 32'd2052};
        vecs[4] = '{1'b0, 32'd2052, 32'h00000000, 32'h82804002, 1'b0, 1'b0, 32'd0};

        rst = 1'b1; mem_load = 1'b1;
        req = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req3 = 1'b0; req_we3 = 1'b0; req_addr3 = 32'd0; req_wdata3 = 32'd0;
        @(negedge clk);
        chk("rst_ready",   32'(req_ready),  32'd1);
        chk("rst_valid",   32'(resp_valid), 32'd0);
        chk("rst_err",     32'(resp_err),   32'd0);
        chk("rst_rdata",   resp_rdata,      32'd0);
        chk("rst_addr",    mem_address,     32'd0);
        chk("rst_wdata",   mem_data_in,     32'd0);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        rst = 1'b0; mem_load = 1'b0;

        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                    vecs[i].exp_err, vecs[i].hold, vecs[i].next_addr);

        // Make sure resp_rdata is non-zero so the reset clearing it is visible.
        run_txn(1'b0, 32'd2048, 32'h0, 32'hc2002844, 1'b0, 1'b0, 32'd0);

        // Reset during WAIT aborts the read with no response.
        req = 1'b1; req_we = 1'b0; req_addr = 32'd2116; req_wdata = 32'h13579BDF;
        @(negedge clk);
        req = 1'b0;
        chk("abort_rd", 32'(mem_rd), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_wait_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",   32'(req_ready),  32'd1);
        chk("abort_valid",   32'(resp_valid), 32'd0);
        chk("abort_err",     32'(resp_err),   32'd0);
        chk("abort_rdata",   resp_rdata,      32'd0);
        chk("abort_addr",    mem_address,     32'd0);
        chk("abort_wdata",   mem_data_in,     32'd0);
        chk("abort_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        @(negedge clk);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        model_rdata = 32'd0;
        run_txn(1'b0, 32'd2116, 32'h0, 32'h00000001, 1'b0, 1'b0, 32'd0);

        // Latency-3 instance: WAIT spans three cycles, response at A+5.
        req3 = 1'b1; req_addr3 = 32'd2048;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req3 = 1'b0;
            chk("l3_mem_rd",     32'(mem_rd3),     32'(k == 1));
            chk("l3_resp_valid", 32'(resp_valid3), 32'(k == 5));
            chk("l3_ready",      32'(req_ready3),  32'(k == 6));
            if (k == 5) begin
                chk("l3_rdata", resp_rdata3, 32'hc2002844);
                chk("l3_err",   32'(resp_err3), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
